// File: rtl/keypad_scanner_if.sv
// Keypad bundle between the scanner and the physical key matrix.
// Handshake: key_valid is a one-cycle, push-only strobe with no ready;
// key_code is valid in the cycle key_valid is high and holds until the
// next strobe. row/col are level signals with no handshake.
interface keypad_scanner_if;
  logic [3:0] row;        // active-low row sense, asynchronous to clk
  logic [3:0] col;        // active-low column drive, exactly one bit low
  logic [3:0] key_code;   // row_idx*4 + col_idx of the last accepted key
  logic       key_valid;  // one-cycle strobe when key_code updates
  logic       key_held;   // high from acceptance until release accepted

  modport master (input row, output col, key_code, key_valid, key_held);
  modport slave  (output row, input col, key_code, key_valid, key_held);
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: walks an active-low column drive, debounces
// a single pressed key over DEB_TICKS dwell ticks, reports its code once,
// and then tracks the release with the same debounce.
module keypad_scanner #(
  parameter int PRE_W     = 16,
  parameter int DEB_TICKS = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  keypad_scanner_if.master        kp,
  output logic [1:0]              state_o
);

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  localparam logic [3:0] DEB_LIM = 4'(DEB_TICKS);

  state_t           state_q;
  logic [3:0]       row_meta_q;
  logic [3:0]       rs_q;
  logic [PRE_W-1:0] pre_q;
  logic [1:0]       col_idx_q;
  logic [3:0]       pat_q;
  logic [3:0]       deb_cnt_q;
  logic [3:0]       deb_cnt_d;
  logic [3:0]       code_q;
  logic             valid_q;
  logic             held_q;
  logic             tick;
  logic             one_low;
  logic [1:0]       row_idx;

  assign tick = &pre_q;

  // Exactly one row line pulled low means a single unambiguous key.
  always_comb begin
    one_low = 1'b0;
    case (rs_q)
      4'b1110, 4'b1101, 4'b1011, 4'b0111: one_low = 1'b1;
      default:                            one_low = 1'b0;
    endcase
  end

  // Row index of the captured pattern's single low bit.
  always_comb begin
    row_idx = 2'd0;
    case (pat_q)
      4'b1101: row_idx = 2'd1;
      4'b1011: row_idx = 2'd2;
      4'b0111: row_idx = 2'd3;
      default: row_idx = 2'd0;
    endcase
  end

  // Debounce counter increment that sticks at all-ones instead of wrapping.
  always_comb begin
    deb_cnt_d = (deb_cnt_q == 4'hF) ? 4'hF : deb_cnt_q + 4'd1;
  end

  // Two-flop synchronizer; idles high like the pulled-up rows.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      row_meta_q <= 4'hF;
      rs_q       <= 4'hF;
    end else begin
      row_meta_q <= kp.row;
      rs_q       <= row_meta_q;
    end
  end

  // Free-running dwell prescaler; its all-ones value is the tick.
  always_ff @(posedge clk) begin
    if (!rst_n) pre_q <= '0;
    else        pre_q <= pre_q + 1'b1;
  end

  // Scan/debounce/hold/release sequencer; all decisions taken on ticks.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= SCAN;
      col_idx_q <= 2'd0;
      pat_q     <= 4'hF;
      deb_cnt_q <= 4'd0;
      code_q    <= 4'd0;
      valid_q   <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (tick) begin
        case (state_q)
          SCAN: begin
            if (one_low) begin
              pat_q     <= rs_q;
              deb_cnt_q <= 4'd1;
              state_q   <= DEBOUNCE;
            end else begin
              col_idx_q <= col_idx_q + 2'd1;
            end
          end
          DEBOUNCE: begin
            if (rs_q == pat_q) begin
              deb_cnt_q <= deb_cnt_d;
              if (deb_cnt_d == DEB_LIM) begin
                code_q  <= {row_idx, col_idx_q};
                valid_q <= 1'b1;
                held_q  <= 1'b1;
                state_q <= HELD;
              end
            end else begin
              state_q   <= SCAN;
              col_idx_q <= col_idx_q + 2'd1;
            end
          end
          HELD: begin
            if (rs_q == 4'hF) begin
              deb_cnt_q <= 4'd1;
              state_q   <= RELEASE;
            end
          end
          RELEASE: begin
            if (rs_q == 4'hF) begin
              deb_cnt_q <= deb_cnt_d;
              if (deb_cnt_d == DEB_LIM) begin
                held_q    <= 1'b0;
                state_q   <= SCAN;
                col_idx_q <= col_idx_q + 2'd1;
              end
            end else begin
              state_q <= HELD;
            end
          end
          default: state_q <= SCAN;
        endcase
      end
    end
  end

  assign kp.col       = ~(4'b0001 << col_idx_q);
  assign kp.key_code  = code_q;
  assign kp.key_valid = valid_q;
  assign kp.key_held  = held_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: emulates a 4x4 key matrix, runs a tick-level
// reference model of the keypad behaviour and checks reported keys through
// a scoreboard queue drained by an independent monitor.
`timescale 1ns/1ps
module tb_keypad_scanner;
  localparam int PRE_W = 2;
  localparam int DEB   = 4;
  localparam int DWELL = 1 << PRE_W;

  // ---------------- clock / reset ----------------
  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] state_dbg;
  always #5 clk = ~clk;

  keypad_scanner_if kif();

  keypad_scanner #(.PRE_W(PRE_W), .DEB_TICKS(DEB)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .kp      (kif.master),
    .state_o (state_dbg)
  );

  // ---------------- key matrix emulation ----------------
  // pressed[r*4+c] shorts row r to column c.
  logic [15:0] pressed = '0;
  always_comb begin
    kif.row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !kif.col[c]) kif.row[r] = 1'b0;
  end

  // ---------------- scoreboard ----------------
  logic [3:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (one call per dwell tick) ----------------
  // mode: 0 scanning, 1 confirming a press, 2 key down, 3 confirming release
  int         m_mode = 0;
  int         m_col  = 0;
  int         m_cnt  = 0;
  logic [3:0] m_pat  = 4'hF;
  logic [3:0] m_code = 4'd0;
  logic       m_held = 1'b0;

  function automatic logic [3:0] sensed(input logic [15:0] keys, input int c);
    logic [3:0] rs;
    rs = 4'hF;
    for (int r = 0; r < 4; r++) if (keys[r*4+c]) rs[r] = 1'b0;
    return rs;
  endfunction

  function automatic int low_row(input logic [3:0] rs);
    for (int r = 0; r < 4; r++) if (!rs[r]) return r;
    return 0;
  endfunction

  task automatic model_tick(input logic [3:0] rs);
    case (m_mode)
      0: if ($countones(~rs) == 1) begin
           m_pat = rs; m_cnt = 1; m_mode = 1;
         end else m_col = (m_col + 1) % 4;
      1: if (rs == m_pat) begin
           m_cnt++;
           if (m_cnt == DEB) begin
             m_code = 4'(low_row(m_pat) * 4 + m_col);
             exp_q.push_back(m_code);
             m_held = 1'b1; m_mode = 2;
           end
         end else begin m_mode = 0; m_col = (m_col + 1) % 4; end
      2: if (rs == 4'hF) begin m_cnt = 1; m_mode = 3; end
      default: if (rs == 4'hF) begin
           m_cnt++;
           if (m_cnt == DEB) begin m_held = 1'b0; m_mode = 0; m_col = (m_col + 1) % 4; end
         end else m_mode = 2;
    endcase
  endtask

  task automatic check_outputs(input string tag);
    logic [3:0] exp_col;
    exp_col = ~(4'b0001 << m_col);
    chk({tag, "_col"},   kif.col,      exp_col);
    chk({tag, "_held"},  kif.key_held, m_held);
    chk({tag, "_code"},  kif.key_code, m_code);
    chk({tag, "_state"}, state_dbg,    m_mode);
  endtask

  // ---------------- driver tasks ----------------
  // Apply a key set for one full dwell; the model sees it at the closing tick.
  task automatic step(input logic [15:0] keys);
    int c;
    pressed = keys;
    c = m_col;
    repeat (DWELL) @(posedge clk);
    model_tick(sensed(keys, c));
    #1;
    check_outputs("tick");
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    m_mode = 0; m_col = 0; m_cnt = 0; m_pat = 4'hF; m_code = 4'd0; m_held = 1'b0;
    check_outputs("rst");
    chk("rst_valid", kif.key_valid, 1'b0);
  endtask

  function automatic logic [15:0] rand_keys();
    logic [15:0] k;
    int n;
    k = '0;
    n = $urandom_range(0, 2);
    for (int i = 0; i < n; i++) k[$urandom_range(0, 15)] = 1'b1;
    return k;
  endfunction

  // ---------------- monitor ----------------
  logic       prev_valid = 1'b0;
  logic [3:0] mon_exp;
  always @(negedge clk) begin
    if (kif.key_valid) begin
      chk("valid_single_cycle", prev_valid, 1'b0);
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_key: got code %0d expected no key_valid at %0t", kif.key_code, $time);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("key_code", kif.key_code, mon_exp);
      end
    end
    prev_valid = kif.key_valid;
  end

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected test end");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  localparam logic [15:0] K9    = 16'h0200;  // row 2, column 1
  localparam logic [15:0] KPAIR = 16'h0101;  // rows 0 and 2 on column 0

  initial begin
    repeat (3) @(posedge clk);
    #1;
    do_reset();

    // Idle scan: 64 cycles with no key.
    for (int i = 0; i < 16; i++) step('0);

    // Single stable press on column 1, row 2.
    for (int i = 0; i < 10; i++) step(K9);

    // Release glitch while held, then a clean release.
    step('0); step('0);
    step(K9);
    for (int i = 0; i < 5; i++) step('0);

    // Bounce: press drops out two ticks after detection.
    for (int i = 0; i < 20 && m_mode != 1; i++) step(K9);
    step(K9);
    for (int i = 0; i < 4; i++) step('0);

    // Two rows low on the same column: ignored.
    for (int i = 0; i < 8; i++) step(KPAIR);
    for (int i = 0; i < 4; i++) step('0);

    // Reset while held.
    for (int i = 0; i < 20 && m_mode != 2; i++) step(K9);
    pressed = '0;
    do_reset();
    for (int i = 0; i < 8; i++) step('0);

    // Randomized key activity.
    for (int n = 0; n < 40; n++) begin
      logic [15:0] k;
      int len;
      k   = rand_keys();
      len = $urandom_range(1, 10);
      for (int i = 0; i < len; i++) step(k);
      if ($urandom_range(0, 15) == 0) do_reset();
    end
    for (int i = 0; i < 8; i++) step('0);

    repeat (4) @(posedge clk);
    #1;
    chk("pending_keys", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
